// File: rtl/i2c_seq_pkg.sv
// rtl/i2c_seq_pkg.sv - iicmb register map, command codes, status codes and sequencer states
package i2c_seq_pkg;

  typedef enum logic [1:0] {
    REG_CSR  = 2'd0,
    REG_DPR  = 2'd1,
    REG_CMDR = 2'd2,
    REG_FSMR = 2'd3
  } iicmb_reg_ofst_t;

  typedef enum logic [2:0] {
    CMD_WAIT    = 3'b000,
    CMD_WRITE   = 3'b001,
    CMD_RD_AK   = 3'b010,
    CMD_RD_NAK  = 3'b011,
    CMD_START   = 3'b100,
    CMD_STOP    = 3'b101,
    CMD_SET_BUS = 3'b110
  } iicmb_cmdr_t;

  typedef enum logic [2:0] {
    ST_DONE     = 3'd0,
    ST_NAK      = 3'd1,
    ST_ARB_LOST = 3'd2,
    ST_ERR      = 3'd3,
    ST_TIMEOUT  = 3'd4
  } seq_status_t;

  localparam logic [7:0] CSR_E  = 8'h80;
  localparam logic [7:0] CSR_IE = 8'h40;

  localparam int CMDR_DON = 7;
  localparam int CMDR_NAK = 6;
  localparam int CMDR_AL  = 5;
  localparam int CMDR_ERR = 4;

  typedef enum logic [2:0] {
    S_INIT_CSR,
    S_IDLE,
    S_WR_DPR,
    S_WR_CMDR,
    S_WAIT_DONE,
    S_RD_CMDR,
    S_RD_DPR,
    S_RESP
  } seq_state_t;

  // A completion byte with no flag set is treated as a core error.
  function automatic seq_status_t decode_cmdr(input logic [7:0] cmdr);
    if (cmdr[CMDR_ERR])      return ST_ERR;
    else if (cmdr[CMDR_AL])  return ST_ARB_LOST;
    else if (cmdr[CMDR_NAK]) return ST_NAK;
    else if (cmdr[CMDR_DON]) return ST_DONE;
    else                     return ST_ERR;
  endfunction

  function automatic logic is_read_op(input logic [2:0] op);
    return (op == CMD_RD_AK) || (op == CMD_RD_NAK);
  endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// rtl/wb_single_xfer.sv - single Wishbone read/write engine, one access at a time
module wb_single_xfer #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic          wb_we,
  output logic [AW-1:0] wb_adr,
  output logic [DW-1:0] wb_dat_w,
  input  logic          wb_ack,
  input  logic [DW-1:0] wb_dat_r
);

  logic          active;
  logic [AW-1:0] adr_q;
  logic          we_q;
  logic [DW-1:0] dat_q;

  // done is a one-cycle pulse while the bus is idle, so a start seen in that
  // cycle is refused and the bus always gets at least one idle cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      active <= 1'b0;
      done   <= 1'b0;
      rdata  <= '0;
      adr_q  <= '0;
      we_q   <= 1'b0;
      dat_q  <= '0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start && !done) begin
          active <= 1'b1;
          adr_q  <= addr;
          we_q   <= we;
          dat_q  <= wdata;
        end
      end else if (wb_ack) begin
        active <= 1'b0;
        done   <= 1'b1;
        rdata  <= wb_dat_r;
      end
    end
  end

  assign wb_cyc   = active;
  assign wb_stb   = active;
  assign wb_we    = active & we_q;
  assign wb_adr   = active ? adr_q : '0;
  assign wb_dat_w = active ? dat_q : '0;

endmodule

// File: rtl/i2c_wb_cmd_sequencer.sv
// rtl/i2c_wb_cmd_sequencer.sv - byte-level I2C op to iicmb WB register sequencer
// I2C_SEQ_POLL_EN: poll CMDR for completion instead of using irq_i
module i2c_wb_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8,
  parameter int DONE_TIMEOUT  = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [2:0]               req_op_i,
  input  logic [7:0]               req_data_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [2:0]               rsp_status_o,
  output logic [7:0]               rsp_data_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic                     ack_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     irq_i,
  output logic                     busy_o
);

`ifdef I2C_SEQ_POLL_EN
  localparam logic [7:0] CSR_INIT = CSR_E;
`else
  localparam logic [7:0] CSR_INIT = CSR_E | CSR_IE;
`endif

  localparam bit          TMO_EN  = (DONE_TIMEOUT > 0);
  localparam logic [31:0] TMO_LIM = (DONE_TIMEOUT > 0) ? 32'(DONE_TIMEOUT - 1) : 32'd0;

  seq_state_t          state, state_d;
  logic [2:0]          op_q;
  logic [7:0]          data_q;
  seq_status_t         status_q, status_d, cmdr_status;
  logic [7:0]          rsp_data_q;
  logic [31:0]         tmo_cnt;
  logic                tmo_hit;
  logic                accept;
  logic                set_status;
  logic                load_rdata;

  logic                x_start;
  iicmb_reg_ofst_t     x_addr;
  logic                x_we;
  logic [7:0]          x_wdata;
  logic                x_done;
  logic [WB_DATA_WIDTH-1:0] x_rdata;

  wb_single_xfer #(
    .AW (WB_ADDR_WIDTH),
    .DW (WB_DATA_WIDTH)
  ) u_xfer (
    .clk      (clk_i),
    .resetn   (rst_i),
    .start    (x_start),
    .addr     (WB_ADDR_WIDTH'(x_addr)),
    .we       (x_we),
    .wdata    (WB_DATA_WIDTH'(x_wdata)),
    .done     (x_done),
    .rdata    (x_rdata),
    .wb_cyc   (cyc_o),
    .wb_stb   (stb_o),
    .wb_we    (we_o),
    .wb_adr   (adr_o),
    .wb_dat_w (dat_o),
    .wb_ack   (ack_i),
    .wb_dat_r (dat_i)
  );

`ifdef I2C_SEQ_POLL_EN
  logic unused_irq;
  assign unused_irq = irq_i;
`endif

  assign accept      = (state == S_IDLE) && req_valid_i;
  assign tmo_hit     = TMO_EN && (tmo_cnt >= TMO_LIM);
  assign cmdr_status = decode_cmdr(x_rdata[7:0]);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= S_INIT_CSR;
      op_q       <= '0;
      data_q     <= '0;
      status_q   <= ST_DONE;
      rsp_data_q <= '0;
      tmo_cnt    <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q       <= req_op_i;
        data_q     <= req_data_i;
        status_q   <= ST_DONE;
        rsp_data_q <= '0;
        tmo_cnt    <= '0;
      end
      if (state == S_WAIT_DONE && tmo_cnt != '1) tmo_cnt <= tmo_cnt + 32'd1;
      if (set_status) status_q <= status_d;
      if (load_rdata) rsp_data_q <= x_rdata[7:0];
    end
  end

  // x_start drops in the done cycle so the engine never re-launches the access
  // that just finished before the state register moves on.
  always_comb begin
    state_d    = state;
    x_start    = 1'b0;
    x_addr     = REG_CSR;
    x_we       = 1'b0;
    x_wdata    = '0;
    set_status = 1'b0;
    status_d   = ST_DONE;
    load_rdata = 1'b0;
    case (state)
      S_INIT_CSR: begin
        x_start = !x_done;
        x_we    = 1'b1;
        x_wdata = CSR_INIT;
        if (x_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (req_valid_i)
          state_d = (req_op_i == CMD_SET_BUS || req_op_i == CMD_WRITE) ? S_WR_DPR : S_WR_CMDR;
      end
      S_WR_DPR: begin
        x_start = !x_done;
        x_addr  = REG_DPR;
        x_we    = 1'b1;
        x_wdata = data_q;
        if (x_done) state_d = S_WR_CMDR;
      end
      S_WR_CMDR: begin
        x_start = !x_done;
        x_addr  = REG_CMDR;
        x_we    = 1'b1;
        x_wdata = {5'b0, op_q};
        if (x_done) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
`ifdef I2C_SEQ_POLL_EN
        x_start = !x_done;
        x_addr  = REG_CMDR;
        if (x_done && (|x_rdata[7:4])) begin
          set_status = 1'b1;
          status_d   = cmdr_status;
          state_d    = (is_read_op(op_q) && cmdr_status == ST_DONE) ? S_RD_DPR : S_RESP;
        end else if (x_done && tmo_hit) begin
          set_status = 1'b1;
          status_d   = ST_TIMEOUT;
          state_d    = S_RESP;
        end
`else
        if (irq_i) begin
          state_d = S_RD_CMDR;
        end else if (tmo_hit) begin
          set_status = 1'b1;
          status_d   = ST_TIMEOUT;
          state_d    = S_RESP;
        end
`endif
      end
      S_RD_CMDR: begin
        x_start = !x_done;
        x_addr  = REG_CMDR;
        if (x_done) begin
          set_status = 1'b1;
          status_d   = cmdr_status;
          state_d    = (is_read_op(op_q) && cmdr_status == ST_DONE) ? S_RD_DPR : S_RESP;
        end
      end
      S_RD_DPR: begin
        x_start = !x_done;
        x_addr  = REG_DPR;
        if (x_done) begin
          load_rdata = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_INIT_CSR;
    endcase
  end

  assign req_ready_o  = (state == S_IDLE);
  assign busy_o       = (state != S_IDLE);
  assign rsp_valid_o  = (state == S_RESP);
  assign rsp_status_o = rsp_valid_o ? status_q : 3'd0;
  assign rsp_data_o   = rsp_valid_o ? rsp_data_q : 8'd0;

endmodule

// File: tb/tb_i2c_wb_cmd_sequencer.sv
// tb/tb_i2c_wb_cmd_sequencer.sv - table-driven bench with iicmb WB register and I2C slave model
module tb_i2c_wb_cmd_sequencer;
  import i2c_seq_pkg::*;

`ifdef I2C_SEQ_POLL_EN
  localparam logic [7:0] CSR_EXP = 8'h80;
`else
  localparam logic [7:0] CSR_EXP = 8'hC0;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i, req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [2:0] req_op_i, rsp_status_o;
  logic [7:0] req_data_i, rsp_data_o;
  logic       cyc_o, stb_o, we_o, ack_i, irq_i, busy_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o, dat_i;

  i2c_wb_cmd_sequencer #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .DONE_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_status_o(rsp_status_o), .rsp_data_o(rsp_data_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .ack_i(ack_i), .dat_i(dat_i), .irq_i(irq_i), .busy_o(busy_o)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Core register file plus a simple I2C slave answering at address 0x22
  typedef struct packed {
    logic        we;
    logic [1:0]  adr;
    logic [7:0]  dat;
    logic [31:0] cyc;
  } wb_rec_t;

  wb_rec_t    wb_log[$];
  logic [7:0] wr_bytes[$];
  logic [31:0] cycle;
  logic [7:0] csr, dpr, dpr_rd, cmd_stat, nxt_stat, rd_cnt;
  logic       pend, after_start;
  logic [1:0] dly;
  logic       hold_irq;
  logic [7:0] force_stat;
  logic [1:0] irq_dly;

  function automatic logic [7:0] bfm_stat(input logic [2:0] op, input logic [7:0] d, input logic as);
    if (op == CMD_WRITE && as) return (d[7:1] == 7'h22) ? 8'h80 : 8'h40;
    return 8'h80;
  endfunction

  always @(posedge clk) begin
    if (!rst_i) begin
      ack_i <= 1'b0; irq_i <= 1'b0; dat_i <= 8'h00; pend <= 1'b0; dly <= 2'd0;
      cmd_stat <= 8'h00; nxt_stat <= 8'h00; after_start <= 1'b0;
      csr <= 8'h00; dpr <= 8'h00; dpr_rd <= 8'h00; rd_cnt <= 8'h00; cycle <= 32'd0;
    end else begin
      cycle <= cycle + 32'd1;
      ack_i <= 1'b0;
      if (pend) begin
        if (dly == 2'd0) begin
          pend     <= 1'b0;
          cmd_stat <= nxt_stat;
          if (csr[6]) irq_i <= 1'b1;
        end else dly <= dly - 2'd1;
      end
      if (cyc_o && stb_o && !ack_i) begin
        ack_i <= 1'b1;
        wb_log.push_back('{we_o, adr_o, dat_o, cycle});
        if (we_o) begin
          if (adr_o == 2'd0) csr <= dat_o;
          else if (adr_o == 2'd1) dpr <= dat_o;
          else if (adr_o == 2'd2) begin
            cmd_stat <= 8'h00;
            irq_i    <= 1'b0;
            pend     <= !hold_irq;
            dly      <= irq_dly;
            nxt_stat <= (force_stat != 8'h00) ? force_stat : bfm_stat(dat_o[2:0], dpr, after_start);
            if (dat_o[2:0] == CMD_START) after_start <= 1'b1;
            else if (dat_o[2:0] == CMD_WRITE) begin
              after_start <= 1'b0;
              if (!after_start) wr_bytes.push_back(dpr);
            end
            if (dat_o[2:0] == CMD_RD_AK || dat_o[2:0] == CMD_RD_NAK) begin
              dpr_rd <= 8'd100 + rd_cnt;
              rd_cnt <= rd_cnt + 8'd1;
            end
          end
        end else begin
          case (adr_o)
            2'd0: dat_i <= csr;
            2'd1: dat_i <= dpr_rd;
            2'd2: begin dat_i <= cmd_stat; irq_i <= 1'b0; end
            default: dat_i <= 8'h00;
          endcase
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic send_req(input logic [2:0] op, input logic [7:0] d, output bit ok);
    wait_ready(ok);
    if (!ok) return;
    req_valid_i = 1'b1; req_op_i = op; req_data_i = d;
    @(negedge clk);
    req_valid_i = 1'b0; req_op_i = 3'd0; req_data_i = 8'h00;
  endtask

  task automatic wait_rsp(output bit ok, output logic [31:0] at);
    ok = 1'b0; at = 32'd0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid_o) begin ok = 1'b1; at = cycle; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [7:0] d,
                       output bit ok, output logic [2:0] st, output logic [7:0] rd, output logic [31:0] at);
    st = 3'd7; rd = 8'hFF; at = 32'd0;
    send_req(op, d, ok);
    if (!ok) return;
    wait_rsp(ok, at);
    if (!ok) return;
    st = rsp_status_o; rd = rsp_data_o;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
  endtask

  function automatic int last_cmdr_idx();
    for (int i = wb_log.size() - 1; i >= 0; i--)
      if (wb_log[i].we && wb_log[i].adr == 2'd2) return i;
    return -1;
  endfunction

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] force_s;
    logic [2:0] exp_st;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit ok;
    logic [2:0] st;
    logic [7:0] rd;
    logic [31:0] at;
    int mark, idx;

    vecs.push_back('{CMD_START, 8'h00, 8'h00, ST_DONE, 8'h00});
    vecs.push_back('{CMD_WRITE, 8'h44, 8'h00, ST_DONE, 8'h00});
    for (int i = 0; i < 32; i++) vecs.push_back('{CMD_WRITE, 8'(i), 8'h00, ST_DONE, 8'h00});
    vecs.push_back('{CMD_STOP, 8'h00, 8'h00, ST_DONE, 8'h00});
    vecs.push_back('{CMD_START, 8'h00, 8'h00, ST_DONE, 8'h00});
    vecs.push_back('{CMD_WRITE, 8'h45, 8'h00, ST_DONE, 8'h00});
    for (int i = 0; i < 31; i++) vecs.push_back('{CMD_RD_AK, 8'h00, 8'h00, ST_DONE, 8'(100 + i)});
    vecs.push_back('{CMD_RD_NAK, 8'h00, 8'h00, ST_DONE, 8'd131});
    vecs.push_back('{CMD_STOP, 8'h00, 8'h00, ST_DONE, 8'h00});
    vecs.push_back('{CMD_START, 8'h00, 8'h00, ST_DONE, 8'h00});
    vecs.push_back('{CMD_WRITE, 8'h50, 8'h00, ST_NAK, 8'h00});
    vecs.push_back('{CMD_WRITE, 8'hA1, 8'h20, ST_ARB_LOST, 8'h00});
    vecs.push_back('{CMD_WRITE, 8'hA2, 8'h10, ST_ERR, 8'h00});
    vecs.push_back('{CMD_WRITE, 8'hA3, 8'h30, ST_ERR, 8'h00});
    vecs.push_back('{CMD_WRITE, 8'hA4, 8'hC0, ST_NAK, 8'h00});
    vecs.push_back('{CMD_STOP, 8'h00, 8'h00, ST_DONE, 8'h00});

    rst_i = 1'b0; req_valid_i = 1'b0; req_op_i = 3'd0; req_data_i = 8'h00; rsp_ready_i = 1'b0;
    hold_irq = 1'b0; force_stat = 8'h00; irq_dly = 2'd2;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cyc", cyc_o, 0);
    check("rst_stb", stb_o, 0);
    check("rst_we", we_o, 0);
    check("rst_adr", adr_o, 0);
    check("rst_dat", dat_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_status", rsp_status_o, 0);
    check("rst_rsp_data", rsp_data_o, 0);
    check("rst_req_ready", req_ready_o, 0);
    rst_i = 1'b1;
    mark = wb_log.size();
    wait_ready(ok);
    check("init_ready", ok, 1);
    check("init_wb_count", wb_log.size() - mark, 1);
    if (wb_log.size() > mark) begin
      check("init_we", wb_log[mark].we, 1);
      check("init_adr", wb_log[mark].adr, REG_CSR);
      check("init_csr", wb_log[mark].dat, CSR_EXP);
    end

    // SET_BUS 5 with response held for several cycles
    mark = wb_log.size();
    send_req(CMD_SET_BUS, 8'h05, ok);
    check("setbus_accept", ok, 1);
    check("setbus_busy", busy_o, 1);
    check("setbus_ready_low", req_ready_o, 0);
    wait_rsp(ok, at);
    check("setbus_rsp", ok, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("setbus_hold_valid[%0d]", k), rsp_valid_o, 1);
      check($sformatf("setbus_hold_status[%0d]", k), rsp_status_o, ST_DONE);
      check($sformatf("setbus_hold_ready[%0d]", k), req_ready_o, 0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check("setbus_rsp_cleared", rsp_valid_o, 0);
    if (wb_log.size() >= mark + 3) begin
      check("setbus_dpr_wr", {wb_log[mark].we, wb_log[mark].adr, wb_log[mark].dat}, {1'b1, REG_DPR, 8'h05});
      check("setbus_cmdr_wr", {wb_log[mark+1].we, wb_log[mark+1].adr, wb_log[mark+1].dat}, {1'b1, REG_CMDR, 8'h06});
      check("setbus_cmdr_rd", {wb_log[mark+2].we, wb_log[mark+2].adr}, {1'b0, REG_CMDR});
    end else check("setbus_wb_count", wb_log.size() - mark, 3);
`ifndef I2C_SEQ_POLL_EN
    check("setbus_wb_exact", wb_log.size() - mark, 3);
`endif

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      force_stat = vecs[i].force_s;
      irq_dly    = 2'(i % 3);
      do_op(vecs[i].op, vecs[i].data, ok, st, rd, at);
      check($sformatf("vec%0d_ok", i), ok, 1);
      check($sformatf("vec%0d_status", i), st, vecs[i].exp_st);
      check($sformatf("vec%0d_data", i), rd, vecs[i].exp_d);
      idx = last_cmdr_idx();
      check($sformatf("vec%0d_cmdr_op", i), (idx >= 0) ? 32'(wb_log[idx].dat) : 32'hFFFF, {29'd0, vecs[i].op});
    end
    force_stat = 8'h00;
    irq_dly    = 2'd2;
    check("bfm_byte_count", wr_bytes.size(), 36);
    for (int i = 0; i < 32 && i < wr_bytes.size(); i++)
      check($sformatf("bfm_byte[%0d]", i), wr_bytes[i], 8'(i));

    // Withheld completion gives TIMEOUT 16 cycles into WAIT_DONE
    hold_irq = 1'b1;
    mark = wb_log.size();
    do_op(CMD_WRITE, 8'h11, ok, st, rd, at);
    check("tmo_ok", ok, 1);
    check("tmo_status", st, ST_TIMEOUT);
    check("tmo_data", rd, 0);
    idx = -1;
    for (int i = mark; i < wb_log.size(); i++)
      if (wb_log[i].we && wb_log[i].adr == 2'd2 && idx < 0) idx = i;
    check("tmo_cmdr_seen", idx >= 0, 1);
`ifdef I2C_SEQ_POLL_EN
    if (idx >= 0) check("tmo_window", (at - wb_log[idx].cyc >= 16) && (at - wb_log[idx].cyc <= 30), 1);
`else
    if (idx >= 0) check("tmo_latency", at - wb_log[idx].cyc, 19);
    check("tmo_no_reads", wb_log.size() - mark, 2);
`endif
    hold_irq = 1'b0;
    do_op(CMD_STOP, 8'h00, ok, st, rd, at);
    check("after_tmo_ok", ok, 1);
    check("after_tmo_status", st, ST_DONE);

    // Reset while the CMDR write strobe is up
    hold_irq = 1'b1;
    send_req(CMD_STOP, 8'h00, ok);
    check("rstmid_accept", ok, 1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cyc_o && stb_o && we_o && adr_o == 2'd2) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("rstmid_strobe_seen", ok, 1);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_cyc", cyc_o, 0);
    check("rstmid_stb", stb_o, 0);
    check("rstmid_ready", req_ready_o, 0);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    hold_irq = 1'b0;
    mark = wb_log.size();
    wait_ready(ok);
    check("rstmid_reinit_ready", ok, 1);
    check("rstmid_reinit_count", wb_log.size() - mark, 1);
    if (wb_log.size() > mark)
      check("rstmid_reinit_csr", {wb_log[mark].we, wb_log[mark].adr, wb_log[mark].dat}, {1'b1, REG_CSR, CSR_EXP});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
